// File: rtl/stage4_dict_ctrl_if.sv
// Batch-in / snapshot-out handshake bundle between stage 3, the dictionary controller and stage 4.
// master = batch source and snapshot sink; slave = the dictionary controller.
interface stage4_dict_ctrl_if #(parameter int FW = 8);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      lane_valid;
    logic [15:0]     pmap_1, pmap_2, pmap_3;
    logic [3*FW-1:0] head_1, head_2, head_3;
    logic            out_valid;
    logic            out_ready;
    logic [FW-1:0]   pid_1, pid_2, pid_3;
    logic [FW-1:0]   mc_1, mc_2, mc_3;
    logic [FW-1:0]   mt_1, mt_2, mt_3;
    logic [2:0]      lane_err;

    modport master (
        output in_valid, lane_valid, pmap_1, pmap_2, pmap_3, head_1, head_2, head_3, out_ready,
        input  in_ready, out_valid, pid_1, pid_2, pid_3, mc_1, mc_2, mc_3, mt_1, mt_2, mt_3, lane_err
    );

    modport slave (
        input  in_valid, lane_valid, pmap_1, pmap_2, pmap_3, head_1, head_2, head_3, out_ready,
        output in_ready, out_valid, pid_1, pid_2, pid_3, mc_1, mc_2, mc_3, mt_1, mt_2, mt_3, lane_err
    );
endinterface

// File: rtl/stage4_dict_ctrl.sv
// FAST copy-operator dictionary (PID/MC/MT) for stage 4; lanes of a batch are applied 1->2->3.
// Optional macro DICT_CTRL_CFG_LOAD_EN adds a direct dictionary load port honoured in IDLE.

module stage4_dict_lane_eval #(parameter int FW = 8) (
    input  logic            valid,
    input  logic [15:0]     pmap,
    input  logic [3*FW-1:0] head,
    input  logic [FW-1:0]   dict_pid,
    input  logic [FW-1:0]   dict_mc,
    input  logic [FW-1:0]   dict_mt,
    output logic [FW-1:0]   eff_pid,
    output logic [FW-1:0]   eff_mc,
    output logic [FW-1:0]   eff_mt,
    output logic            err,
    output logic            wr
);
    logic          legal;
    logic [FW-1:0] hb0, hb1, hb2, b_mc, b_mt;

    assign hb0   = head[3*FW-1 -: FW];
    assign hb1   = head[2*FW-1 -: FW];
    assign hb2   = head[FW-1:0];
    assign legal = pmap[15] && (pmap[11:0] == 12'h000);
    assign wr    = valid && legal;
    assign err   = valid && !legal;

    // Present fields consume head bytes in order, so each field's byte depends on those before it
    assign b_mc = pmap[14] ? hb1 : hb0;
    always_comb begin
        case ({pmap[14], pmap[13]})
            2'b00:   b_mt = hb0;
            2'b11:   b_mt = hb2;
            default: b_mt = hb1;
        endcase
    end

    assign eff_pid = (wr && pmap[14]) ? hb0  : dict_pid;
    assign eff_mc  = (wr && pmap[13]) ? b_mc : dict_mc;
    assign eff_mt  = (wr && pmap[12]) ? b_mt : dict_mt;
endmodule

module stage4_dict_ctrl #(
    parameter int            FW      = 8,
    parameter logic [FW-1:0] PID_RST = '0,
    parameter logic [FW-1:0] MC_RST  = '0,
    parameter logic [FW-1:0] MT_RST  = '0
) (
    input logic clk,
    input logic rst,
`ifdef DICT_CTRL_CFG_LOAD_EN
    input logic          cfg_we,
    input logic [FW-1:0] cfg_pid,
    input logic [FW-1:0] cfg_mc,
    input logic [FW-1:0] cfg_mt,
`endif
    stage4_dict_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, L1, L2, L3, DONE} state_t;

    state_t                    state;
    logic [FW-1:0]             d_pid, d_mc, d_mt;
    logic [2:0]                lv_q;
    logic [2:0][15:0]          pmap_q;
    logic [2:0][3*FW-1:0]      head_q;
    logic [2:0][FW-1:0]        pid_q, mc_q, mt_q;
    logic [2:0]                err_q;
    logic                      ov_q;
    logic [1:0]                lane;
    logic [FW-1:0]             e_pid, e_mc, e_mt;
    logic                      e_err, e_wr;
    logic                      cfg_we_w;
    logic [FW-1:0]             cfg_pid_w, cfg_mc_w, cfg_mt_w;

`ifdef DICT_CTRL_CFG_LOAD_EN
    assign cfg_we_w  = cfg_we;
    assign cfg_pid_w = cfg_pid;
    assign cfg_mc_w  = cfg_mc;
    assign cfg_mt_w  = cfg_mt;
`else
    assign cfg_we_w  = 1'b0;
    assign cfg_pid_w = '0;
    assign cfg_mc_w  = '0;
    assign cfg_mt_w  = '0;
`endif

    always_comb begin
        lane = 2'd0;
        case (state)
            L2:      lane = 2'd1;
            L3:      lane = 2'd2;
            default: lane = 2'd0;
        endcase
    end

    // One evaluator shared by all lanes: sequential processing is what gives in-order dependency
    stage4_dict_lane_eval #(.FW(FW)) u_eval (
        .valid    (lv_q[lane]),
        .pmap     (pmap_q[lane]),
        .head     (head_q[lane]),
        .dict_pid (d_pid),
        .dict_mc  (d_mc),
        .dict_mt  (d_mt),
        .eff_pid  (e_pid),
        .eff_mc   (e_mc),
        .eff_mt   (e_mt),
        .err      (e_err),
        .wr       (e_wr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            d_pid  <= PID_RST;
            d_mc   <= MC_RST;
            d_mt   <= MT_RST;
            lv_q   <= '0;
            pmap_q <= '0;
            head_q <= '0;
            pid_q  <= '0;
            mc_q   <= '0;
            mt_q   <= '0;
            err_q  <= '0;
            ov_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we_w) begin
                        d_pid <= cfg_pid_w;
                        d_mc  <= cfg_mc_w;
                        d_mt  <= cfg_mt_w;
                    end else if (bus.in_valid) begin
                        lv_q   <= bus.lane_valid;
                        pmap_q <= {bus.pmap_3, bus.pmap_2, bus.pmap_1};
                        head_q <= {bus.head_3, bus.head_2, bus.head_1};
                        err_q  <= '0;
                        state  <= L1;
                    end
                end
                L1, L2, L3: begin
                    pid_q[lane] <= e_pid;
                    mc_q[lane]  <= e_mc;
                    mt_q[lane]  <= e_mt;
                    err_q[lane] <= e_err;
                    if (e_wr) begin
                        d_pid <= e_pid;
                        d_mc  <= e_mc;
                        d_mt  <= e_mt;
                    end
                    state <= (state == L1) ? L2 : (state == L2) ? L3 : DONE;
                end
                DONE: begin
                    // Snapshot is presented one cycle after the last lane lands
                    if (!ov_q) begin
                        ov_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        ov_q  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !cfg_we_w;
    assign bus.out_valid = ov_q;
    assign bus.lane_err  = err_q;
    assign bus.pid_1     = pid_q[0];
    assign bus.pid_2     = pid_q[1];
    assign bus.pid_3     = pid_q[2];
    assign bus.mc_1      = mc_q[0];
    assign bus.mc_2      = mc_q[1];
    assign bus.mc_3      = mc_q[2];
    assign bus.mt_1      = mt_q[0];
    assign bus.mt_2      = mt_q[1];
    assign bus.mt_3      = mt_q[2];
endmodule
